// File: rtl/clock_gate_ctrl.sv
// Multi-channel clock-gating controller: per-channel idle hysteresis FSM feeding a latch+AND gating cell.
// Optional gated-cycle statistics are built when CLOCK_GATE_STATS_EN is defined.
module clock_gate_ctrl #(
  parameter int unsigned NUM_CH   = 4,
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned WAKE_CYC = 2,
  localparam int unsigned SEL_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              test_en,
  input  logic [CNT_W-1:0]  hold_cfg,
  input  logic [NUM_CH-1:0] busy,
  input  logic [NUM_CH-1:0] force_on,
  output logic [NUM_CH-1:0] gclk,
  output logic [NUM_CH-1:0] ready,
  output logic [NUM_CH-1:0] gated,
  input  logic [SEL_W-1:0]  stat_sel,
  input  logic              stat_clr,
  output logic [15:0]       stat_data
);

  localparam int unsigned WCNT_W = (WAKE_CYC > 1) ? $clog2(WAKE_CYC + 1) : 1;

  typedef enum logic [1:0] {ST_RUN, ST_IDLE_CNT, ST_GATED, ST_WAKE} state_t;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              ready_q, gated_q;
    logic              ch_en_c;
    logic              en_latch;

    // State register; ready/gated are registered decodes of the next state
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q <= ST_RUN;
        cnt_q   <= '0;
        wcnt_q  <= '0;
        ready_q <= 1'b1;
        gated_q <= 1'b0;
      end else begin
        state_q <= state_d;
        cnt_q   <= cnt_d;
        wcnt_q  <= wcnt_d;
        ready_q <= (state_d == ST_RUN) || (state_d == ST_IDLE_CNT);
        gated_q <= (state_d == ST_GATED);
      end
    end

    // Next-state: force_on outranks the countdown expiry while idling
    always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      wcnt_d  = wcnt_q;
      case (state_q)
        ST_RUN: begin
          if (!busy[i] && !force_on[i]) begin
            if (hold_cfg == '0) begin
              state_d = ST_GATED;
            end else begin
              state_d = ST_IDLE_CNT;
              cnt_d   = hold_cfg;
            end
          end
        end
        ST_IDLE_CNT: begin
          if (busy[i])                      state_d = ST_RUN;
          else if (force_on[i])             cnt_d   = hold_cfg;
          else if (cnt_q == CNT_W'(1))      state_d = ST_GATED;
          else                              cnt_d   = cnt_q - CNT_W'(1);
        end
        ST_GATED: begin
          if (busy[i] || force_on[i]) begin
            if (WAKE_CYC == 0) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_WAKE;
              wcnt_d  = WCNT_W'(WAKE_CYC);
            end
          end
        end
        ST_WAKE: begin
          if (wcnt_q == WCNT_W'(1)) state_d = ST_RUN;
          else                      wcnt_d  = wcnt_q - WCNT_W'(1);
        end
        default: state_d = ST_RUN;
      endcase
    end

    assign ch_en_c = (state_q != ST_GATED) || force_on[i] || test_en;

    // Enable only changes while clk is low, so the AND never clips a high phase
    always_latch begin
      if (rst)       en_latch <= 1'b1;
      else if (!clk) en_latch <= ch_en_c;
    end

    assign gclk[i]  = clk & en_latch;
    assign ready[i] = ready_q;
    assign gated[i] = gated_q;
  end

`ifdef CLOCK_GATE_STATS_EN
  logic [15:0] stat_cnt_q [NUM_CH];

  // Saturating gated-cycle counters; clear has priority over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < int'(NUM_CH); j++) stat_cnt_q[j] <= '0;
    end else begin
      for (int j = 0; j < int'(NUM_CH); j++) begin
        if (stat_clr)
          stat_cnt_q[j] <= '0;
        else if (gated[j] && (stat_cnt_q[j] != 16'hFFFF))
          stat_cnt_q[j] <= stat_cnt_q[j] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          stat_data <= '0;
    else if (32'(stat_sel) < NUM_CH)  stat_data <= stat_cnt_q[stat_sel];
    else                              stat_data <= '0;
  end
`else
  logic unused_stat;
  assign unused_stat = ^{stat_sel, stat_clr};
  assign stat_data   = '0;
`endif

endmodule
